// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes, FSM state encodings and helpers for the stage sequencer.
`default_nettype none

package stage_sequencer_pkg;

  localparam logic [2:0] STAGE_IDLE      = 3'd0;
  localparam logic [2:0] STAGE_FETCH     = 3'd1;
  localparam logic [2:0] STAGE_DECODE    = 3'd2;
  localparam logic [2:0] STAGE_EXECUTE   = 3'd3;
  localparam logic [2:0] STAGE_MEMORY    = 3'd4;
  localparam logic [2:0] STAGE_WRITEBACK = 3'd5;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd1;
  localparam logic [STATE_W-1:0] ST_STALL     = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALTED    = 3'd4;

  localparam int STALL_CNT_W = 8;

  // A running stage code must lie in FETCH..last.
  function automatic logic stage_in_range(input logic [2:0] s, input logic [2:0] last);
    return (s >= STAGE_FETCH) && (s <= last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_sequencer_sat_counter.sv
// sat_counter: up-counter with synchronous clear and a saturate-or-wrap select.
`default_nettype none

module sat_counter #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic at_max;
  assign at_max = (count == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !(SATURATE && at_max)) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage_sequencer.sv
// stage_sequencer: five-stage instruction sequencer with memory stall, halt and single-step control.
// Rev 1.0
`default_nettype none

module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STALL_STAGE = 4,
  parameter int MAX_STALL   = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               single_step,
  input  logic               step,
  input  logic               mem_wait,
  output logic [2:0]         stage,
  output logic               instr_done,
  output logic               halted,
  output logic               stall_timeout,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [2:0] LAST_STAGE  = 3'(NUM_STAGES);
  localparam logic [2:0] HOLD_STAGE  = 3'(STALL_STAGE);
  localparam logic [2:0] AFTER_HOLD  = 3'(STALL_STAGE + 1);
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(MAX_STALL);

  logic [STATE_W-1:0]     state, next_state;
  logic [2:0]             next_stage;
  logic                   stall_hold;
  logic                   stall_exit;
  logic                   force_adv;
  logic                   instr_end;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // State register plus the registered outputs that follow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      stage         <= STAGE_IDLE;
      instr_done    <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= next_state;
      stage         <= next_stage;
      instr_done    <= instr_end;
      stall_timeout <= stall_timeout | force_adv;
    end
  end

  always_comb begin
    next_state = state;
    next_stage = stage;
    stall_hold = 1'b0;
    stall_exit = 1'b0;
    force_adv  = 1'b0;
    instr_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        next_stage = STAGE_IDLE;
        if (run) begin
          next_state = ST_RUN;
          next_stage = STAGE_FETCH;
        end
      end
      ST_RUN: begin
        if (!stage_in_range(stage, LAST_STAGE)) begin
          next_state = ST_IDLE;
          next_stage = STAGE_IDLE;
        end else if (stage == HOLD_STAGE && mem_wait) begin
          next_state = ST_STALL;
          stall_hold = 1'b1;
        end else if (stage == LAST_STAGE) begin
          // Control inputs are only honoured at an instruction boundary.
          instr_end = 1'b1;
          if (halt_req) begin
            next_state = ST_HALTED;
            next_stage = STAGE_IDLE;
          end else if (!run) begin
            next_state = ST_IDLE;
            next_stage = STAGE_IDLE;
          end else if (single_step) begin
            next_state = ST_STEP_WAIT;
            next_stage = STAGE_IDLE;
          end else begin
            next_stage = STAGE_FETCH;
          end
        end else begin
          next_stage = stage + 3'd1;
        end
      end
      ST_STALL: begin
        if (mem_wait && stall_cnt < STALL_LIMIT) begin
          stall_hold = 1'b1;
        end else begin
          next_state = ST_RUN;
          next_stage = AFTER_HOLD;
          stall_exit = 1'b1;
          force_adv  = mem_wait;
        end
      end
      ST_STEP_WAIT: begin
        next_stage = STAGE_IDLE;
        if (halt_req) begin
          next_state = ST_HALTED;
        end else if (!run) begin
          next_state = ST_IDLE;
        end else if (step) begin
          next_state = ST_RUN;
          next_stage = STAGE_FETCH;
        end
      end
      ST_HALTED: begin
        next_stage = STAGE_IDLE;
        if (resume) begin
          if (run) begin
            next_state = ST_RUN;
            next_stage = STAGE_FETCH;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_stage = STAGE_IDLE;
      end
    endcase
  end

  always_comb begin
    halted = (state == ST_HALTED);
  end

  sat_counter #(
    .WIDTH    (COUNT_W),
    .SATURATE (1'b1)
  ) u_cycle_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (1'b0),
    .enable (stage != STAGE_IDLE),
    .count  (cycle_count)
  );

  sat_counter #(
    .WIDTH    (COUNT_W),
    .SATURATE (1'b0)
  ) u_instr_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (1'b0),
    .enable (instr_end),
    .count  (instr_count)
  );

  sat_counter #(
    .WIDTH    (STALL_CNT_W),
    .SATURATE (1'b1)
  ) u_stall_count (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (stall_exit),
    .enable (stall_hold),
    .count  (stall_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer.
`default_nettype none

module tb_stage_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        resume;
  logic        single_step;
  logic        step;
  logic        mem_wait;
  logic [2:0]  stage;
  logic        instr_done;
  logic        halted;
  logic        stall_timeout;
  logic [15:0] cycle_count;
  logic [15:0] instr_count;

  int vectors;
  int miscompares;

  stage_sequencer #(
    .NUM_STAGES  (5),
    .STALL_STAGE (4),
    .MAX_STALL   (15),
    .COUNT_W     (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .halt_req      (halt_req),
    .resume        (resume),
    .single_step   (single_step),
    .step          (step),
    .mem_wait      (mem_wait),
    .stage         (stage),
    .instr_done    (instr_done),
    .halted        (halted),
    .stall_timeout (stall_timeout),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    run         = 1'b0;
    halt_req    = 1'b0;
    resume      = 1'b0;
    single_step = 1'b0;
    step        = 1'b0;
    mem_wait    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stage", 32'(stage), 0);
    check("rst_done", 32'(instr_done), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_timeout", 32'(stall_timeout), 0);
    check("rst_cycles", 32'(cycle_count), 0);
    check("rst_instrs", 32'(instr_count), 0);

    // Free run: 1..5 repeating, Instr_Done after each stage 5
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("run_stage", 32'(stage), 32'((k - 1) % 5 + 1));
      check("run_done", 32'(instr_done), 32'(k == 6 || k == 11));
    end
    @(negedge clk);
    check("run_stage13", 32'(stage), 3);
    check("run_cycles", 32'(cycle_count), 12);
    check("run_instrs", 32'(instr_count), 2);

    // Short stall: three wait cycles hold stage 4 for four cycles
    @(negedge clk);
    check("stall_s4", 32'(stage), 4);
    mem_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_hold", 32'(stage), 4);
      mem_wait = (k < 2);
    end
    @(negedge clk);
    check("stall_s5", 32'(stage), 5);
    check("stall_no_to", 32'(stall_timeout), 0);

    // Stuck wait: 15 held cycles then forced advance
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("to_walk", 32'(stage), 32'(k));
    end
    mem_wait = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("to_hold", 32'(stage), 4);
      check("to_not_yet", 32'(stall_timeout), 0);
    end
    @(negedge clk);
    check("to_forced_s5", 32'(stage), 5);
    check("to_sticky", 32'(stall_timeout), 1);
    mem_wait = 1'b0;

    // Halt requested at stage 2 completes the instruction first
    @(negedge clk);
    check("halt_s1", 32'(stage), 1);
    @(negedge clk);
    check("halt_s2", 32'(stage), 2);
    halt_req = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check("halt_finish", 32'(stage), 32'(k));
      check("halt_not_yet", 32'(halted), 0);
    end
    @(negedge clk);
    check("halt_stage0", 32'(stage), 0);
    check("halt_flag", 32'(halted), 1);
    check("halt_done", 32'(instr_done), 1);
    check("halt_instrs", 32'(instr_count), 5);
    @(negedge clk);
    check("halt_hold", 32'(stage), 0);
    check("halt_done_once", 32'(instr_done), 0);
    check("halt_to_sticky", 32'(stall_timeout), 1);
    resume = 1'b1;
    @(negedge clk);
    check("resume_s1", 32'(stage), 1);
    check("resume_flag", 32'(halted), 0);
    resume      = 1'b0;
    halt_req    = 1'b0;
    single_step = 1'b1;

    // Single step: pause after stage 5 until a Step pulse
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("ss_walk", 32'(stage), 32'(k));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ss_wait", 32'(stage), 0);
      check("ss_not_halted", 32'(halted), 0);
    end
    step = 1'b1;
    @(negedge clk);
    check("ss_step_s1", 32'(stage), 1);
    step = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("ss_pass", 32'(stage), 32'(k));
    end
    @(negedge clk);
    check("ss_wait2", 32'(stage), 0);
    @(negedge clk);
    check("ss_wait3", 32'(stage), 0);
    step     = 1'b1;
    halt_req = 1'b1;
    @(negedge clk);
    check("ss_halt_wins_stage", 32'(stage), 0);
    check("ss_halt_wins_flag", 32'(halted), 1);
    step        = 1'b0;
    halt_req    = 1'b0;
    single_step = 1'b0;

    // Asynchronous reset mid-instruction
    resume = 1'b1;
    @(negedge clk);
    check("ar_s1", 32'(stage), 1);
    resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_s3", 32'(stage), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_stage0", 32'(stage), 0);
    check("ar_cycles0", 32'(cycle_count), 0);
    check("ar_instrs0", 32'(instr_count), 0);
    check("ar_timeout0", 32'(stall_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first_s1", 32'(stage), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
